// File: rtl/flick_conditioner.sv
// Push-button conditioner: two-flop synchronizer, press/release debounce FSM,
// and a fixed-length flick pulse per accepted press plus a wrapping press counter.
module flick_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       flick,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PL_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS   = 3'd1,
    FIRE    = 3'd2,
    HELD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  logic             r_s1;
  logic             r_btn_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  // Outputs are assigned on the transition into the state they describe, so
  // they always reflect the state being entered on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= 1'b0;
      r_btn_s     <= 1'b0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      flick       <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= 8'd0;
    end else begin
      r_s1    <= btn_raw;
      r_btn_s <= r_s1;
      case (r_state)
        IDLE: begin
          if (r_btn_s) begin
            r_state <= PRESS;
            r_cnt   <= CNT_ONE;
          end
        end
        PRESS: begin
          if (!r_btn_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state     <= FIRE;
            r_cnt       <= '0;
            flick       <= 1'b1;
            btn_level   <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        FIRE: begin
          // Button is ignored here so the pulse is never cut short.
          if (r_cnt == PL_LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
            flick   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!r_btn_s) begin
            r_state <= RELEASE;
            r_cnt   <= CNT_ONE;
          end
        end
        RELEASE: begin
          if (r_btn_s) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            btn_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          flick     <= 1'b0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule
